road_input_conditioner: RTL and testbench
=========================================

Name: road_input_conditioner

Overview:
- Upstream stage that conditions raw board inputs before they reach the traffic light controller on the 10 MHz domain.
- Synchronises and debounces the secondary-road vehicle sensor and the fault button.
- Turns the sensor into a latched service request that is held until the controller serves it with a secondary green.
- Turns the fault button into a sticky fault flag that is released only by an explicit clear.

Parameters:
- DEBOUNCE_CYCLES, 100000, stable cycles needed before a debounced level changes (10 ms at 10 MHz); must be >= 2.
- CNT_W, 17, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  10 MHz system clock.
- reset_n  input  1  asynchronous active-low reset.
- sensorRaw  input  1  raw, asynchronous vehicle-present input for the secondary road (switch or button).
- faultRaw  input  1  raw, asynchronous fault button, active-high.
- faultClear  input  1  synchronous, active-high request to release the sticky fault.
- secondaryGreen  input  1  green bit of the secondary-road RYG output, fed back from the controller.
- secondaryRoadSensor  output  1  latched service request to the controller.
- fault  output  1  sticky fault to the controller.
- sensorDebounced  output  1  debounced sensor level, for LED and debug.

Behaviour:
- Reset values (asynchronous, on reset_n low): all synchroniser flops 0, both debounce counters 0, debounced levels 0, FSM in IDLE, and all outputs 0.
- Synchroniser: each raw input passes through 2 flops. Nothing downstream uses an unsynchronised raw value.
- Debounce (identical per channel):
  - If the synchronised value equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and the mismatch still holds, the debounced level takes the synchronised value and the counter clears.
  - Any glitch back to the debounced level restarts the count.
  - Latency from a clean raw edge to the debounced change is DEBOUNCE_CYCLES+2 cycles.
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles is never passed through.
- Request FSM (states IDLE, REQUEST, SERVING); secondaryRoadSensor is registered and equals 1 only in REQUEST:
  - IDLE -> REQUEST on a rising edge of debounced sensor (detected with a 1-cycle-delayed copy of the debounced level).
  - REQUEST -> SERVING when secondaryGreen is 1. A sensor drop while in REQUEST does not cancel the request.
  - SERVING -> REQUEST when secondaryGreen falls and the debounced sensor is still 1 (vehicle still waiting).
  - SERVING -> IDLE when secondaryGreen falls and the debounced sensor is 0.
  - secondaryRoadSensor asserts 1 cycle after the debounced rise and deasserts 1 cycle after secondaryGreen goes high.
  - If the debounced rise and secondaryGreen=1 coincide in IDLE, go to REQUEST. No service has been credited for that vehicle yet.
- Fault latch:
  - fault sets 1 cycle after a debounced fault rising edge.
  - faultClear clears fault only when debounced fault is 0; faultClear while the button is still held is ignored.
  - A simultaneous set and clear resolves to set.
  - While fault=1, the FSM is forced to IDLE and held there, and secondaryRoadSensor is 0.
  - After fault clears, a sensor that is still high does not create a request; a new debounced rising edge is required.
- Reset mid-operation: everything returns to reset values immediately. A sensor held high through reset release produces a request after DEBOUNCE_CYCLES+2 cycles plus 1 cycle, because the debounced level rises from 0.
- secondaryGreen is already synchronous to clk and is used directly, without synchronisation.

Test Plan (simulation with DEBOUNCE_CYCLES=4, CNT_W=3):
- Sensor pulse tests:
  - sensorRaw high for 3 cycles, then low -> sensorDebounced stays 0 and secondaryRoadSensor stays 0.
  - sensorRaw held high -> sensorDebounced rises 6 cycles after the raw edge, and secondaryRoadSensor rises 1 cycle later.
- Request service: with a request pending and sensorRaw held high, secondaryGreen pulses high for 10 cycles -> secondaryRoadSensor drops 1 cycle after green rises and re-asserts 1 cycle after green falls. Repeat with sensorRaw low before green falls -> the FSM returns to IDLE and the output stays 0.
- Bounce: sensorRaw toggles 1,0,1,1,0,1,1,1,1 (one value per cycle) -> the counter restarts on each 0, and sensorDebounced rises only after the final run of four synchronised 1s.
- Fault sticky:
  - faultRaw high for 8 cycles -> fault=1 at raw edge +7 cycles and secondaryRoadSensor forced to 0.
  - faultClear pulsed while faultRaw is still high -> fault stays 1.
  - faultClear pulsed after the debounced fault has fallen -> fault drops to 0 on the next cycle.
  - Set and clear in the same cycle -> fault=1.
- Async reset: assert reset_n low mid-REQUEST and mid-debounce count, between clock edges -> all outputs are 0 immediately, without waiting for a clock edge. Release reset with sensorRaw held high -> secondaryRoadSensor=1 at 7 cycles after release.

Source files
------------

// File: rtl/road_input_conditioner.sv
// Conditions the raw vehicle sensor and fault button for the traffic light controller:
// two-flop synchronisers, per-channel debounce, a latched service request and a sticky fault.
module road_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sensorRaw,
  input  logic faultRaw,
  input  logic faultClear,
  input  logic secondaryGreen,
  output logic secondaryRoadSensor,
  output logic fault,
  output logic sensorDebounced
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVING
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sensor_meta, sensor_sync;
  logic             fault_meta, fault_sync;
  logic [CNT_W-1:0] sensor_cnt, fault_cnt;
  logic             sensor_deb, fault_deb;
  logic             sensor_deb_d, fault_deb_d;
  logic             sensor_rise, fault_rise;
  logic             fault_q;
  state_t           state, state_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sensor_meta <= 1'b0;
      sensor_sync <= 1'b0;
      fault_meta  <= 1'b0;
      fault_sync  <= 1'b0;
    end else begin
      sensor_meta <= sensorRaw;
      sensor_sync <= sensor_meta;
      fault_meta  <= faultRaw;
      fault_sync  <= fault_meta;
    end
  end

  // A level only changes after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sensor_cnt <= '0;
      sensor_deb <= 1'b0;
    end else if (sensor_sync == sensor_deb) begin
      sensor_cnt <= '0;
    end else if (sensor_cnt == CNT_LAST) begin
      sensor_cnt <= '0;
      sensor_deb <= sensor_sync;
    end else begin
      sensor_cnt <= sensor_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_cnt <= '0;
      fault_deb <= 1'b0;
    end else if (fault_sync == fault_deb) begin
      fault_cnt <= '0;
    end else if (fault_cnt == CNT_LAST) begin
      fault_cnt <= '0;
      fault_deb <= fault_sync;
    end else begin
      fault_cnt <= fault_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sensor_deb_d <= 1'b0;
      fault_deb_d  <= 1'b0;
    end else begin
      sensor_deb_d <= sensor_deb;
      fault_deb_d  <= fault_deb;
    end
  end

  assign sensor_rise = sensor_deb & ~sensor_deb_d;
  assign fault_rise  = fault_deb & ~fault_deb_d;

  // Setting wins over clearing; a clear is honoured only once the button is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else if (fault_rise) begin
      fault_q <= 1'b1;
    end else if (faultClear && !fault_deb) begin
      fault_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (fault_q) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (sensor_rise)     state_next = REQUEST;
        REQUEST: if (secondaryGreen)  state_next = SERVING;
        SERVING: if (!secondaryGreen) state_next = sensor_deb ? REQUEST : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign secondaryRoadSensor = (state == REQUEST) && !fault_q;
  assign fault               = fault_q;
  assign sensorDebounced     = sensor_deb;

endmodule

// File: tb/tb_road_input_conditioner.sv
// Self-checking bench for road_input_conditioner: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_road_input_conditioner;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sensorRaw = 1'b0;
  logic faultRaw = 1'b0;
  logic faultClear = 1'b0;
  logic secondaryGreen = 1'b0;
  logic secondaryRoadSensor;
  logic fault;
  logic sensorDebounced;

  int checks = 0;
  int errors = 0;

  typedef enum int {VEH_NONE, VEH_WAITING, VEH_SERVED} veh_t;

  bit   sync_s[$];
  bit   sync_f[$];
  bit   win_s[$];
  bit   win_f[$];
  bit   m_deb_s, m_deb_f, m_prev_s, m_prev_f, m_fault;
  veh_t m_veh;

  always #50 clk = ~clk;

  road_input_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sensorRaw(sensorRaw),
    .faultRaw(faultRaw),
    .faultClear(faultClear),
    .secondaryGreen(secondaryGreen),
    .secondaryRoadSensor(secondaryRoadSensor),
    .fault(fault),
    .sensorDebounced(sensorDebounced)
  );

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change right after a falling edge and are held for n rising edges.
  task automatic applyStimulus(input logic s, input logic f, input logic c, input logic g,
                               input int n);
    sensorRaw      = s;
    faultRaw       = f;
    faultClear     = c;
    secondaryGreen = g;
    repeat (n) @(negedge clk);
  endtask

  // A level is settled when the last N synchronised samples all disagree with it.
  function automatic bit settled(input bit win[$], input bit lvl);
    if (win.size() < N) return 1'b0;
    foreach (win[i]) if (win[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelStep();
    bit   seen_s, seen_f, rise_s, rise_f, nd_s, nd_f, nf;
    veh_t nv;
    if (!reset_n) begin
      sync_s = '{1'b0, 1'b0};
      sync_f = '{1'b0, 1'b0};
      win_s.delete();
      win_f.delete();
      m_deb_s = 0; m_deb_f = 0; m_prev_s = 0; m_prev_f = 0; m_fault = 0;
      m_veh = VEH_NONE;
      return;
    end
    seen_s = sync_s.pop_front();
    sync_s.push_back(sensorRaw);
    seen_f = sync_f.pop_front();
    sync_f.push_back(faultRaw);
    win_s.push_back(seen_s);
    if (win_s.size() > N) void'(win_s.pop_front());
    win_f.push_back(seen_f);
    if (win_f.size() > N) void'(win_f.pop_front());
    nd_s = settled(win_s, m_deb_s) ? !m_deb_s : m_deb_s;
    nd_f = settled(win_f, m_deb_f) ? !m_deb_f : m_deb_f;
    rise_s = m_deb_s && !m_prev_s;
    rise_f = m_deb_f && !m_prev_f;
    nf = rise_f ? 1'b1 : ((faultClear && !m_deb_f) ? 1'b0 : m_fault);
    nv = m_veh;
    if (m_fault) nv = VEH_NONE;
    else if (m_veh == VEH_NONE && rise_s) nv = VEH_WAITING;
    else if (m_veh == VEH_WAITING && secondaryGreen) nv = VEH_SERVED;
    else if (m_veh == VEH_SERVED && !secondaryGreen) nv = m_deb_s ? VEH_WAITING : VEH_NONE;
    m_prev_s = m_deb_s;
    m_prev_f = m_deb_f;
    m_deb_s  = nd_s;
    m_deb_f  = nd_f;
    m_fault  = nf;
    m_veh    = nv;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      checkOutput("model_deb", sensorDebounced, m_deb_s);
      checkOutput("model_fault", fault, m_fault);
      checkOutput("model_request", secondaryRoadSensor, (m_veh == VEH_WAITING) && !m_fault);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_request", secondaryRoadSensor, 1'b0);
    checkOutput("reset_fault", fault, 1'b0);
    checkOutput("reset_deb", sensorDebounced, 1'b0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 3);

    applyStimulus(1, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 10);
    checkOutput("short_pulse_deb", sensorDebounced, 1'b0);
    checkOutput("short_pulse_request", secondaryRoadSensor, 1'b0);

    applyStimulus(1, 0, 0, 0, 5);
    checkOutput("hold_deb_edge5", sensorDebounced, 1'b0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("hold_deb_edge6", sensorDebounced, 1'b1);
    checkOutput("hold_request_edge6", secondaryRoadSensor, 1'b0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("hold_request_edge7", secondaryRoadSensor, 1'b1);

    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("green_rise_drop", secondaryRoadSensor, 1'b0);
    applyStimulus(1, 0, 0, 1, 9);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("green_fall_reassert", secondaryRoadSensor, 1'b1);

    applyStimulus(1, 0, 0, 1, 2);
    applyStimulus(0, 0, 0, 1, 8);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("served_to_idle", secondaryRoadSensor, 1'b0);
    checkOutput("served_deb_low", sensorDebounced, 1'b0);

    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 5);
    checkOutput("bounce_deb_edge10", sensorDebounced, 1'b0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("bounce_deb_edge11", sensorDebounced, 1'b1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("bounce_request", secondaryRoadSensor, 1'b1);

    applyStimulus(1, 1, 0, 0, 6);
    checkOutput("fault_edge6", fault, 1'b0);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("fault_edge7", fault, 1'b1);
    checkOutput("fault_masks_request", secondaryRoadSensor, 1'b0);
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("clear_while_held", fault, 1'b1);
    applyStimulus(1, 0, 0, 0, 4);
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("clear_after_release", fault, 1'b0);
    applyStimulus(1, 0, 0, 0, 10);
    checkOutput("no_request_after_clear", secondaryRoadSensor, 1'b0);

    applyStimulus(1, 1, 1, 0, 8);
    checkOutput("set_beats_clear", fault, 1'b1);
    applyStimulus(1, 0, 0, 0, 8);
    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("fault_cleared_again", fault, 1'b0);

    applyStimulus(0, 0, 0, 0, 8);
    applyStimulus(1, 0, 0, 0, 8);
    applyStimulus(1, 1, 0, 0, 3);
    checkOutput("pre_reset_request", secondaryRoadSensor, 1'b1);
    @(posedge clk);
    #20 reset_n = 1'b0;
    #5;
    checkOutput("async_reset_request", secondaryRoadSensor, 1'b0);
    checkOutput("async_reset_fault", fault, 1'b0);
    checkOutput("async_reset_deb", sensorDebounced, 1'b0);
    @(negedge clk);
    sensorRaw = 1'b1;
    faultRaw  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 6);
    checkOutput("post_reset_edge6", secondaryRoadSensor, 1'b0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("post_reset_edge7", secondaryRoadSensor, 1'b1);

    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 8)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
